// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants and helpers for the seven-segment scanner.
//   SEG_TABLE  - active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F
//   SEG_OFF    - active-high "all segments off" pattern
//   apply_pol  - maps an active-high bit onto the board pin polarity
//   idx_width  - digit index width (clog2 of the digit count, minimum 1)
package seg_scan_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int unsigned idx_width(int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic apply_pol(logic v, bit active_low);
        return v ^ active_low;
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational nibble-to-segment decoder (active-high output).
//   nibble_i - hex digit to display
//   seg_o    - {g,f,e,d,c,b,a}, 1 = segment lit
module hex_to_7seg
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scanner with double buffering,
// per-slot anti-ghosting blanking, decimal points and leading-zero blanking.
//   clk, reset  - single clock, synchronous active-high reset
//   load        - strobe capturing value/dp_in/lz_en into the pending buffer
//   value       - hex nibbles, digit 0 rightmost
//   dp_in       - decimal point enable per digit
//   lz_en       - leading-zero suppression enable
//   anode       - digit select (one-hot when active)
//   segment     - {g,f,e,d,c,b,a}
//   dp_out      - decimal point pin
//   frame_done  - one-cycle pulse at the end of each full scan
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 64,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              segment,
    output logic                    dp_out,
    output logic                    frame_done
);

    localparam int unsigned       CNT_W     = $clog2(CLK_DIV);
    localparam int unsigned       IDX_W     = idx_width(NUM_DIGITS);
    localparam int unsigned       VAL_W     = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic              OFF_BIT   = apply_pol(1'b0, ACTIVE_LOW);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      pend_val_q, pend_val_d, disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic                  pend_lz_q, pend_lz_d, disp_lz_q, disp_lz_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  fd_q, fd_d;

    logic                  frame_end;
    logic [3:0]            nibble;
    logic [6:0]            seg_raw;
    logic [NUM_DIGITS-1:0] zero_from;

    assign frame_end = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

    // Scan counters and buffers. The display buffer only moves at frame end,
    // and a load on that very cycle bypasses the pending buffer.
    always_comb begin
        cnt_d        = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_lz_d    = pend_lz_q;
        pend_valid_d = pend_valid_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        disp_lz_d    = disp_lz_q;

        if (cnt_q == CNT_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        if (frame_end) begin
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_in;
                disp_lz_d  = lz_en;
            end else if (pend_valid_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
                disp_lz_d  = pend_lz_q;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp_in;
            pend_lz_d    = lz_en;
            pend_valid_d = 1'b1;
        end
    end

    // zero_from[i]: nibble i and every nibble above it are zero.
    always_comb begin : p_zero_from
        logic run;
        run       = 1'b1;
        zero_from = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            run = run & (disp_val_q[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
            zero_from[NUM_DIGITS-1-k] = run;
        end
    end

    always_comb begin
        nibble = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nibble = disp_val_q[4*i +: 4];
            end
        end
    end

    hex_to_7seg u_dec (
        .nibble_i (nibble),
        .seg_o    (seg_raw)
    );

    always_comb begin : p_out_next
        logic                  blank;
        logic                  suppress;
        logic                  dp_sel;
        logic [NUM_DIGITS-1:0] anode_ah;
        logic [6:0]            seg_ah;

        blank    = (cnt_q < BLANK_END);
        suppress = 1'b0;
        dp_sel   = 1'b0;
        anode_ah = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                anode_ah[i] = 1'b1;
                dp_sel      = disp_dp_q[i];
                suppress    = disp_lz_q && (i != 0) && zero_from[i];
            end
        end
        seg_ah = suppress ? SEG_OFF : seg_raw;

        if (blank) begin
            anode_ah = '0;
            seg_ah   = SEG_OFF;
            dp_sel   = 1'b0;
        end

        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            anode_d[i] = apply_pol(anode_ah[i], ACTIVE_LOW);
        end
        for (int unsigned s = 0; s < 7; s++) begin
            seg_d[s] = apply_pol(seg_ah[s], ACTIVE_LOW);
        end
        dp_d = apply_pol(dp_sel, ACTIVE_LOW);
        fd_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_lz_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_lz_q    <= 1'b0;
            anode_q      <= {NUM_DIGITS{OFF_BIT}};
            seg_q        <= {7{OFF_BIT}};
            dp_q         <= OFF_BIT;
            fd_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_lz_q    <= pend_lz_d;
            pend_valid_q <= pend_valid_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            disp_lz_q    <= disp_lz_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            fd_q         <= fd_d;
        end
    end

    assign anode      = anode_q;
    assign segment    = seg_q;
    assign dp_out     = dp_q;
    assign frame_done = fd_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display scanner. It is the next-generation driver for the digit/segment outputs of the top-level controller. It adds a configurable digit count, refresh rate, output polarity, tear-free double buffering, anti-ghosting blanking, per-digit decimal points and leading-zero suppression. It sits between the datapath (which presents hex nibbles) and the board display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits; legal range 1..8.
CLK_DIV, 50000, clock cycles per digit slot; must be >= 2.
BLANK_CYCLES, 64, cycles at the start of each slot with all anodes off; must be < CLK_DIV.
ACTIVE_LOW, 1, when 1, anode, segment and dp_out pins are driven active-low.

Ports:
clk  input  1  system clock; the only clock.
reset  input  1  synchronous, active-high reset.
load  input  1  single-cycle strobe; captures value/dp_in/lz_en into the pending buffer.
value  input  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i]; digit 0 is the rightmost.
dp_in  input  NUM_DIGITS  decimal point enable per digit.
lz_en  input  1  leading-zero suppression enable.
anode  output  NUM_DIGITS  digit select, one-hot when active.
segment  output  7  {g,f,e,d,c,b,a}.
dp_out  output  1  decimal point pin.
frame_done  output  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset is synchronous and active-high: clk is the only clock, and reset is sampled on its rising edge.
- State: slot counter cnt (0..CLK_DIV-1), digit index idx (0..NUM_DIGITS-1), pending buffer plus pend_valid flag, display buffer.
- Reset values: cnt=0, idx=0, pend_valid=0, display buffer=0 (value 0, dp 0, lz_en 0).
- Output reset values: all anodes inactive, segment all off, dp_out off, frame_done=0. Inactive/off means 1 when ACTIVE_LOW=1 and 0 otherwise.
- Reset asserted mid-frame aborts the scan, discards the pending buffer, and restarts at idx 0, cnt 0 on the first cycle after release.
- Counter: cnt increments each cycle. At cnt==CLK_DIV-1 it wraps to 0 and idx advances. idx wraps NUM_DIGITS-1 -> 0.
- frame_done: pulses for the cycle in which cnt==CLK_DIV-1 and idx==NUM_DIGITS-1.
- Double buffering:
  - load sets pend_valid and captures the inputs.
  - A later load before the frame end overwrites the pending buffer (last load wins).
  - On the frame_done cycle, if pend_valid, or if load is asserted that same cycle, the display buffer takes the newest data and pend_valid clears. A load coincident with frame_done goes straight to display.
  - The display buffer never changes mid-frame.
- Outputs are registered with 1-cycle latency from (idx, cnt, display buffer).
- Blanking: while cnt < BLANK_CYCLES, all anodes are inactive and the segments are off.
- Outside the blanking window, anode[idx] is active, all other anodes are inactive, segment = decode(nibble idx), and dp_out = dp[idx].
- Leading-zero suppression: when lz_en is set in the display buffer, a digit is blanked (segments off, dp still honoured) if its nibble and every higher nibble are 0. Digit 0 is never suppressed.
- Decode table (active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- The final output is inverted when ACTIVE_LOW=1.

Decomposition:
- Package seg_scan_pkg holds:
  - the 16-entry decode constant table;
  - SEG_OFF;
  - a function for polarity application;
  - localparam width helpers (idx width = clog2(NUM_DIGITS), min 1).
- Natural sub-module: hex_to_7seg, a combinational nibble-to-segment decoder using the package table, instantiated once.
- The counter, buffers and output registers stay in seg_scan_ctrl.

Test Plan:
All directed tests use CLK_DIV=4, BLANK_CYCLES=1, NUM_DIGITS=4, ACTIVE_LOW=1.
1. Reset held 3 cycles, then released. Throughout reset: anode=4'hF, segment=7'h7F, dp_out=1, frame_done=0. First frame_done appears 16 cycles after release.
2. load value=16'h12AF, dp_in=4'b0100, lz_en=0, then wait for frame_done. In the next frame's digit-0 slot: anode=4'b1110, segment=7'h0E. In the digit-2 slot: segment=7'h24 (2) with dp_out=0.
3. Blanking: in every slot, the output for cnt=0 has anode=4'hF. The following 3 cycles show exactly one active anode.
4. Tear test: display holds 16'h12AF. Pulse load with 16'h0000 during the idx=1 slot. Digits 2 and 3 still show 2 and 1. All digits show 0 only after frame_done.
5. Leading zeros: load 16'h0050 with lz_en=1. Digits 3 and 2 are blanked (segment=7'h7F, anode still cycles). Digit 1 shows 7'h12 (5). Digit 0 shows 7'h40 (0).
6. Coincident load with frame_done, then reset mid-slot at idx=2. The new value is displayed in the immediately following frame. After reset, the outputs are at reset values and the scan restarts at digit 0 with pend_valid cleared.
